// File: rtl/commit_rr_mux.sv
// Round-robin commit multiplexer: CH upstream request channels share one registered
// downstream request slot; an in-order ID FIFO routes each response back to its issuer.
module commit_rr_mux #(
   parameter  int CH    = 4,
   parameter  int DW    = 32,
   parameter  int DEPTH = 4,
   localparam int IW    = $clog2(CH),
   localparam int OW    = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [CH-1:0]      ch_req_vaild,
   output logic [CH-1:0]      ch_req_ready,
   input  logic [CH*DW-1:0]   ch_req_data,
   output logic               req_vaild,
   input  logic               req_ready,
   output logic [DW-1:0]      r_in,
   output logic [IW-1:0]      req_id,
   input  logic               rsp_vaild,
   output logic               rsp_ready,
   input  logic [DW-1:0]      rsp_data,
   output logic [CH-1:0]      ch_rsp_vaild,
   input  logic [CH-1:0]      ch_rsp_ready,
   output logic [DW-1:0]      ch_rsp_data,
   output logic [OW-1:0]      outstanding,
   output logic               rsp_err
);

   localparam int PW = $clog2(DEPTH);

   logic [IW-1:0] r_fifo [DEPTH];
   logic [PW-1:0] r_wptr;
   logic [PW-1:0] r_rptr;
   logic [OW-1:0] r_count;
   logic [IW-1:0] r_last_grant;
   logic          r_rsp_err;

   logic [DW-1:0] w_ch_data [CH];
   logic          w_empty;
   logic [IW-1:0] w_head;
   logic          w_pop;
   logic          w_slot_free;
   logic          w_fifo_ok;
   logic          w_found;
   logic [IW-1:0] w_grant_idx;
   logic          w_grant;
   int            w_cand;

   for (genvar gi = 0; gi < CH; gi++) begin : g_unpack
      assign w_ch_data[gi] = ch_req_data[gi*DW +: DW];
   end

   assign w_empty     = (r_count == '0);
   assign w_head      = r_fifo[r_rptr];
   assign rsp_ready   = !w_empty && ch_rsp_ready[w_head];
   assign w_pop       = rsp_vaild && rsp_ready;
   assign ch_rsp_data = rsp_data;
   assign outstanding = r_count;
   assign rsp_err     = r_rsp_err;

   // A pop in the same cycle frees the entry the new push needs.
   assign w_slot_free = !req_vaild || req_ready;
   assign w_fifo_ok   = (r_count < OW'(DEPTH)) || w_pop;
   assign w_grant     = w_slot_free && w_fifo_ok && w_found;

   always_comb begin
      w_found     = 1'b0;
      w_grant_idx = '0;
      w_cand      = 0;
      for (int k = 1; k <= CH; k++) begin
         w_cand = (int'(r_last_grant) + k) % CH;
         if (!w_found && ch_req_vaild[w_cand]) begin
            w_found     = 1'b1;
            w_grant_idx = IW'(w_cand);
         end
      end
   end

   always_comb begin
      ch_req_ready = '0;
      if (w_grant) ch_req_ready[w_grant_idx] = 1'b1;
   end

   always_comb begin
      ch_rsp_vaild = '0;
      if (rsp_vaild && !w_empty) ch_rsp_vaild[w_head] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_grant) r_fifo[r_wptr] <= w_grant_idx;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_vaild    <= 1'b0;
         r_in         <= '0;
         req_id       <= '0;
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_count      <= '0;
         r_last_grant <= IW'(CH - 1);
         r_rsp_err    <= 1'b0;
      end else begin
         if (w_grant) begin
            req_vaild    <= 1'b1;
            r_in         <= w_ch_data[w_grant_idx];
            req_id       <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_wptr       <= r_wptr + PW'(1);
         end else if (req_ready) begin
            req_vaild <= 1'b0;
         end
         if (w_pop) r_rptr <= r_rptr + PW'(1);
         case ({w_grant, w_pop})
            2'b10:   r_count <= r_count + OW'(1);
            2'b01:   r_count <= r_count - OW'(1);
            default: r_count <= r_count;
         endcase
         if (rsp_vaild && w_empty) r_rsp_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_commit_rr_mux.sv
// Self-checking bench for commit_rr_mux: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model.
module tb_commit_rr_mux;
   localparam int CH = 4;
   localparam int DW = 32;
   localparam int DEPTH = 4;
   localparam int IW = $clog2(CH);
   localparam int OW = $clog2(DEPTH + 1);

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic [CH-1:0]      ch_req_vaild = '0;
   logic [CH-1:0]      ch_req_ready;
   logic [CH*DW-1:0]   ch_req_data = '0;
   logic               req_vaild;
   logic               req_ready = 1'b0;
   logic [DW-1:0]      r_in;
   logic [IW-1:0]      req_id;
   logic               rsp_vaild = 1'b0;
   logic               rsp_ready;
   logic [DW-1:0]      rsp_data = '0;
   logic [CH-1:0]      ch_rsp_vaild;
   logic [CH-1:0]      ch_rsp_ready = '0;
   logic [DW-1:0]      ch_rsp_data;
   logic [OW-1:0]      outstanding;
   logic               rsp_err;

   commit_rr_mux #(.CH(CH), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .ch_req_vaild(ch_req_vaild), .ch_req_ready(ch_req_ready), .ch_req_data(ch_req_data),
      .req_vaild(req_vaild), .req_ready(req_ready), .r_in(r_in), .req_id(req_id),
      .rsp_vaild(rsp_vaild), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .ch_rsp_vaild(ch_rsp_vaild), .ch_rsp_ready(ch_rsp_ready), .ch_rsp_data(ch_rsp_data),
      .outstanding(outstanding), .rsp_err(rsp_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail = 0;
   int n_cyc = 0;

   // behavioural model state
   int            m_q[$];
   bit            m_vld;
   logic [DW-1:0] m_data;
   int            m_id;
   int            m_last;
   bit            m_err;
   int            e_grant;
   bit            e_pop;

   task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] lane(input int c);
      return ch_req_data[c*DW +: DW];
   endfunction

   task automatic check_regs();
      check_val("req_vaild", 64'(req_vaild), 64'(m_vld));
      check_val("r_in", 64'(r_in), 64'(m_data));
      check_val("req_id", 64'(req_id), 64'(m_id));
      check_val("outstanding", 64'(outstanding), 64'(m_q.size()));
      check_val("rsp_err", 64'(rsp_err), 64'(m_err));
   endtask

   task automatic do_reset();
      @(negedge clk);
      ch_req_vaild = '0; req_ready = 1'b0; rsp_vaild = 1'b0; ch_rsp_ready = '0;
      reset = 1'b1;
      #2;
      m_q.delete(); m_vld = 0; m_data = '0; m_id = 0; m_last = CH - 1; m_err = 0;
      check_regs();
      reset = 1'b0;
   endtask

   // Drive one cycle of inputs at the falling edge, then check the combinational outputs.
   task automatic phase_a(input logic [CH-1:0] rv, input logic [CH*DW-1:0] data, input logic rr,
                          input logic rspv, input logic [DW-1:0] rspd, input logic [CH-1:0] crr);
      logic [CH-1:0] exp_crr;
      logic [CH-1:0] exp_rspv;
      bit exp_rrdy;
      @(negedge clk);
      ch_req_vaild = rv; ch_req_data = data; req_ready = rr;
      rsp_vaild = rspv; rsp_data = rspd; ch_rsp_ready = crr;
      #1;
      exp_rrdy = (m_q.size() != 0) && crr[m_q[0]];
      exp_rspv = '0;
      if (rspv && m_q.size() != 0) exp_rspv[m_q[0]] = 1'b1;
      e_pop = rspv && exp_rrdy;
      e_grant = -1;
      if ((!m_vld || rr) && (m_q.size() < DEPTH || e_pop)) begin
         for (int k = 1; k <= CH; k++) begin
            if (e_grant < 0 && rv[(m_last + k) % CH]) e_grant = (m_last + k) % CH;
         end
      end
      exp_crr = '0;
      if (e_grant >= 0) exp_crr[e_grant] = 1'b1;
      check_val("ch_req_ready", 64'(ch_req_ready), 64'(exp_crr));
      check_val("rsp_ready", 64'(rsp_ready), 64'(exp_rrdy));
      check_val("ch_rsp_vaild", 64'(ch_rsp_vaild), 64'(exp_rspv));
      check_val("ch_rsp_data", 64'(ch_rsp_data), 64'(rspd));
   endtask

   // Clock the cycle, advance the model, then check the registered outputs.
   task automatic phase_b();
      @(posedge clk);
      if (rsp_vaild && m_q.size() == 0) m_err = 1;
      if (e_pop) void'(m_q.pop_front());
      if (e_grant >= 0) begin
         m_q.push_back(e_grant);
         m_vld = 1; m_data = lane(e_grant); m_id = e_grant; m_last = e_grant;
      end else if (req_ready) begin
         m_vld = 0;
      end
      #1;
      n_cyc++;
      $display("cyc %0d grant=%0d pop=%0d req_vaild=%0b r_in=%h req_id=%0d outstanding=%0d rsp_err=%0b",
               n_cyc, e_grant, e_pop, req_vaild, r_in, req_id, outstanding, rsp_err);
      check_regs();
   endtask

   function automatic logic [CH*DW-1:0] rand_data();
      logic [CH*DW-1:0] d;
      for (int c = 0; c < CH; c++) d[c*DW +: DW] = DW'($urandom);
      return d;
   endfunction

   logic [CH*DW-1:0] dd;

   initial begin
      // Reset then single request on ch2
      do_reset();
      dd = '0; dd[2*DW +: DW] = 32'h0000_00A5;
      phase_a(4'b0100, dd, 1'b1, 1'b0, '0, '0);
      check_val("single_grant", 64'(ch_req_ready), 64'h4);
      phase_b();
      check_val("single_r_in", 64'(r_in), 64'hA5);
      check_val("single_id", 64'(req_id), 64'd2);
      check_val("single_outstanding", 64'(outstanding), 64'd1);

      // Round-robin with immediate responses
      do_reset();
      for (int k = 0; k < 8; k++) begin
         phase_a(4'b1111, rand_data(), 1'b1, m_q.size() != 0, DW'($urandom), 4'b1111);
         check_val("rr_order", 64'(ch_req_ready), 64'(1 << (k % CH)));
         phase_b();
      end

      // FIFO full, then grant in the pop cycle
      do_reset();
      for (int k = 0; k < DEPTH; k++) begin
         phase_a(4'b1111, rand_data(), 1'b1, 1'b0, '0, '0);
         check_val("full_fill", 64'(ch_req_ready), 64'(1 << k));
         phase_b();
      end
      check_val("full_count", 64'(outstanding), 64'(DEPTH));
      phase_a(4'b1111, rand_data(), 1'b1, 1'b0, '0, '0);
      check_val("full_block", 64'(ch_req_ready), 64'h0);
      phase_b();
      phase_a(4'b1111, rand_data(), 1'b1, 1'b1, 32'h5A, 4'b1111);
      check_val("full_pop_grant", 64'(ch_req_ready), 64'h1);
      phase_b();
      check_val("full_hold", 64'(outstanding), 64'(DEPTH));

      // Response routing: ch3 then ch1
      do_reset();
      phase_a(4'b1000, rand_data(), 1'b1, 1'b0, '0, '0);
      phase_b();
      phase_a(4'b0010, rand_data(), 1'b1, 1'b0, '0, '0);
      phase_b();
      phase_a(4'b0000, '0, 1'b1, 1'b1, 32'h11, 4'b0111);
      check_val("route_stall", 64'(rsp_ready), 64'h0);
      check_val("route_stall_v", 64'(ch_rsp_vaild), 64'h8);
      phase_b();
      phase_a(4'b0000, '0, 1'b1, 1'b1, 32'h11, 4'b1111);
      check_val("route_first", 64'(ch_rsp_vaild), 64'h8);
      check_val("route_first_d", 64'(ch_rsp_data), 64'h11);
      phase_b();
      phase_a(4'b0000, '0, 1'b1, 1'b1, 32'h22, 4'b1111);
      check_val("route_second", 64'(ch_rsp_vaild), 64'h2);
      check_val("route_second_d", 64'(ch_rsp_data), 64'h22);
      phase_b();

      // Error flag and asynchronous reset mid-transfer
      do_reset();
      phase_a(4'b0000, '0, 1'b0, 1'b1, 32'h33, 4'b1111);
      check_val("err_rsp_ready", 64'(rsp_ready), 64'h0);
      phase_b();
      check_val("err_set", 64'(rsp_err), 64'h1);
      phase_a(4'b0000, '0, 1'b0, 1'b0, '0, '0);
      phase_b();
      check_val("err_sticky", 64'(rsp_err), 64'h1);
      phase_a(4'b0001, rand_data(), 1'b0, 1'b0, '0, '0);
      phase_b();
      phase_a(4'b0010, rand_data(), 1'b1, 1'b0, '0, '0);
      phase_b();
      check_val("pre_reset_vld", 64'(req_vaild), 64'h1);
      check_val("pre_reset_out", 64'(outstanding), 64'h2);
      do_reset();

      // Randomized traffic against the model
      for (int run = 0; run < 3; run++) begin
         do_reset();
         for (int k = 0; k < 250; k++) begin
            phase_a(CH'($urandom), rand_data(), ($urandom_range(3, 0) != 0),
                    (m_q.size() != 0) ? ($urandom_range(2, 0) != 0) : ($urandom_range(19, 0) == 0),
                    DW'($urandom), CH'($urandom));
            phase_b();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL timeout: got running expected finished");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
